niosii_onchip_mem_arbiter: RTL and testbench
============================================

NIOSII_ONCHIP_MEM_ARBITER -- requirements
Module: niosii_onchip_mem_arbiter

Interface
REQ-001 SHALL expose parameter MEM_WORDS, default 12000, number of valid 32-bit words behind the memory port.
REQ-002 SHALL expose parameter ADDR_W, default 14, word-address width.
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have, for requester k in {0,1}: mk_address input ADDR_W word address; mk_read input 1; mk_write input 1; mk_byteenable input 4; mk_writedata input 32.
REQ-006 SHALL have, for requester k in {0,1}: mk_waitrequest output 1; mk_readdata output 32; mk_readdatavalid output 1.
REQ-007 SHALL have memory-side ports: mem_address output ADDR_W; mem_byteenable output 4; mem_writedata output 32; mem_chipselect output 1; mem_write output 1; mem_clken output 1; mem_readdata input 32, valid one cycle after address is clocked in.
REQ-008 SHALL have err_clr input 1, clears error flag; err_oor output 1, sticky out-of-range flag.

Function
REQ-009 Request k: req_k = mk_read | mk_write; mk_read and mk_write both high SHALL be treated as write only.
REQ-010 Grant SHALL be combinational in the request cycle; at most one of grant_0/grant_1 high per cycle.
REQ-011 Sole requester SHALL be granted; both requesting: grant the one not in last_grant; no request: no grant.
REQ-012 last_grant (1 bit) SHALL update to granted index on every grant edge; unchanged when idle.
REQ-013 mk_waitrequest SHALL equal req_k & ~grant_k; a non-requesting master sees 0.
REQ-014 When granted and address < MEM_WORDS: mem_address/mem_byteenable/mem_writedata SHALL mirror granted master; mem_chipselect=1; mem_write=granted mk_write.
REQ-015 When no grant: mem_chipselect=0, mem_write=0, mem_address/byteenable/writedata hold last driven values (registered mux select).
REQ-016 mem_clken SHALL be 1 in any cycle with a grant or an outstanding read, else 0.
REQ-017 Granted read SHALL set rd_pending=1 and rd_owner=k at the edge; next cycle mk_readdatavalid=1 for owner only, mk_readdata=mem_readdata; fixed latency 1.
REQ-018 Back-to-back reads (either master, any alternation) SHALL sustain one read per cycle with no bubbles.
REQ-019 Write SHALL complete in its grant cycle; no readdatavalid generated.
REQ-020 Granted access with address >= MEM_WORDS SHALL be consumed (waitrequest 0), mem_chipselect=0, mem_write=0; read SHALL return readdatavalid next cycle with readdata 0x00000000.
REQ-021 Out-of-range grant SHALL set err_oor at next edge; err_clr clears it; set and clear same cycle: set wins.
REQ-022 mk_readdata SHALL be 0 when mk_readdatavalid=0.
REQ-023 Under continuous dual requests grants SHALL strictly alternate; no master waits more than 1 cycle.

Reset
REQ-024 reset_n low SHALL asynchronously force: last_grant=1 (master 0 wins first tie), rd_pending=0, rd_owner=0, err_oor=0, mux select=0.
REQ-025 During reset, all mk_readdatavalid=0, mem_chipselect=0, mem_write=0, mem_clken=0, mk_waitrequest=req_k.
REQ-026 Read granted in the cycle reset asserts SHALL produce no readdatavalid after reset release.
REQ-027 Outputs SHALL be glitch-free functions of registered state and current inputs only; no combinational path from mem_readdata to any waitrequest.

Verification
REQ-028 After reset, m0 and m1 read addr 0x0010 and 0x0020 same cycle -> m0 granted cycle 0 (m1_waitrequest=1), m1 cycle 1; m0_readdatavalid cycle 1, m1_readdatavalid cycle 2, data matches memory.
REQ-029 m0 writes 0xA5A5A5A5 byteenable 0x3 to 0x0100, then reads it -> mem_write pulse 1 cycle; read returns lower 16 bits 0xA5A5, upper bytes unchanged.
REQ-030 Both masters stream 8 reads each continuously -> grants alternate m0,m1,...; 16 readdatavalid pulses in 16 consecutive cycles, each to correct owner.
REQ-031 m1 reads address 12000 -> mem_chipselect=0, m1_readdatavalid next cycle with 0x00000000, err_oor=1; err_clr pulse -> err_oor=0; err_clr coincident with another OOR -> stays 1.
REQ-032 reset_n pulsed low in cycle m0 read is granted -> no m0_readdatavalid after release; next tie grants m0.

Source files
------------

// File: rtl/niosii_onchip_mem_arbiter.sv
// Two-master round-robin arbiter in front of a single-port on-chip RAM with 1-cycle read latency.
// Out-of-range accesses are absorbed locally and raise a sticky error flag.
module niosii_onchip_mem_arbiter #(
  parameter int MEM_WORDS = 12000,
  parameter int ADDR_W    = 14
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [3:0]        m0_byteenable,
  input  logic [31:0]       m0_writedata,
  output logic              m0_waitrequest,
  output logic [31:0]       m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [3:0]        m1_byteenable,
  input  logic [31:0]       m1_writedata,
  output logic              m1_waitrequest,
  output logic [31:0]       m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic [31:0]       mem_writedata,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic              mem_clken,
  input  logic [31:0]       mem_readdata,
  input  logic              err_clr,
  output logic              err_oor
);

  logic [ADDR_W-1:0] m_address   [2];
  logic [3:0]        m_byteenable[2];
  logic [31:0]       m_writedata [2];
  logic [31:0]       m_readdata  [2];
  logic [1:0]        req;
  logic [1:0]        is_wr;
  logic [1:0]        grant;
  logic [1:0]        waitreq;
  logic [1:0]        rd_valid;

  logic last_grant_reg;
  logic sel_reg;
  logic rd_pending_reg;
  logic rd_owner_reg;
  logic rd_oor_reg;
  logic err_oor_reg;

  logic any_grant;
  logic grant_idx;
  logic sel;
  logic oor;
  logic rd_grant;
  logic err_oor_next;

  assign m_address[0]    = m0_address;
  assign m_address[1]    = m1_address;
  assign m_byteenable[0] = m0_byteenable;
  assign m_byteenable[1] = m1_byteenable;
  assign m_writedata[0]  = m0_writedata;
  assign m_writedata[1]  = m1_writedata;
  assign req             = {m1_read | m1_write, m0_read | m0_write};
  // read+write together is treated as a plain write
  assign is_wr           = {m1_write, m0_write};

  // No grants while reset is asserted, so waitrequest simply follows the request.
  always_comb begin
    grant = 2'b00;
    if (reset_n) begin
      if (req == 2'b11) grant = last_grant_reg ? 2'b01 : 2'b10;
      else              grant = req;
    end
  end

  assign any_grant = |grant;
  assign grant_idx = grant[1];
  assign sel       = any_grant ? grant_idx : sel_reg;
  assign oor       = 32'(m_address[sel]) >= 32'(MEM_WORDS);
  assign rd_grant  = any_grant & ~is_wr[sel];

  assign mem_address    = m_address[sel];
  assign mem_byteenable = m_byteenable[sel];
  assign mem_writedata  = m_writedata[sel];
  assign mem_chipselect = any_grant & ~oor;
  assign mem_write      = any_grant & ~oor & is_wr[sel];
  assign mem_clken      = any_grant | rd_pending_reg;

  always_comb begin
    err_oor_next = err_oor_reg;
    if (any_grant && oor) err_oor_next = 1'b1;
    else if (err_clr)     err_oor_next = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_reg <= 1'b1;
      sel_reg        <= 1'b0;
      rd_pending_reg <= 1'b0;
      rd_owner_reg   <= 1'b0;
      rd_oor_reg     <= 1'b0;
      err_oor_reg    <= 1'b0;
    end else begin
      rd_pending_reg <= rd_grant;
      err_oor_reg    <= err_oor_next;
      if (any_grant) begin
        last_grant_reg <= grant_idx;
        sel_reg        <= grant_idx;
      end
      if (rd_grant) begin
        rd_owner_reg <= grant_idx;
        rd_oor_reg   <= oor;
      end
    end
  end

  // Out-of-range reads return zero instead of whatever the RAM last produced.
  for (genvar gi = 0; gi < 2; gi++) begin : g_master
    assign waitreq[gi]    = req[gi] & ~grant[gi];
    assign rd_valid[gi]   = rd_pending_reg & (rd_owner_reg == 1'(gi));
    assign m_readdata[gi] = (rd_valid[gi] & ~rd_oor_reg) ? mem_readdata : 32'h0;
  end

  assign m0_waitrequest   = waitreq[0];
  assign m1_waitrequest   = waitreq[1];
  assign m0_readdatavalid = rd_valid[0];
  assign m1_readdatavalid = rd_valid[1];
  assign m0_readdata      = m_readdata[0];
  assign m1_readdata      = m_readdata[1];
  assign err_oor          = err_oor_reg;

endmodule

// File: tb/tb_niosii_onchip_mem_arbiter.sv
// Directed bench for the on-chip memory arbiter; a behavioural RAM preloads word a with 0xC0DE0000|a.
module tb_niosii_onchip_mem_arbiter;

  localparam int MEM_WORDS = 12000;
  localparam int ADDR_W    = 14;

  logic              clk;
  logic              reset_n;
  logic [ADDR_W-1:0] m0_address, m1_address;
  logic              m0_read, m0_write, m1_read, m1_write;
  logic [3:0]        m0_byteenable, m1_byteenable;
  logic [31:0]       m0_writedata, m1_writedata;
  logic              m0_waitrequest, m1_waitrequest;
  logic [31:0]       m0_readdata, m1_readdata;
  logic              m0_readdatavalid, m1_readdatavalid;
  logic [ADDR_W-1:0] mem_address;
  logic [3:0]        mem_byteenable;
  logic [31:0]       mem_writedata;
  logic              mem_chipselect, mem_write, mem_clken;
  logic [31:0]       mem_readdata;
  logic              err_clr, err_oor;

  int n_checks;
  int n_fail;

  niosii_onchip_mem_arbiter #(.MEM_WORDS(MEM_WORDS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_writedata(mem_writedata), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_clken(mem_clken), .mem_readdata(mem_readdata),
    .err_clr(err_clr), .err_oor(err_oor)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: registered read, byte-enabled write, preloaded while reset is held.
  logic [31:0] mem_model [MEM_WORDS];
  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < MEM_WORDS; i++) mem_model[i] <= 32'hC0DE0000 | 32'(i);
    end else if (mem_clken && mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) mem_model[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else begin
        mem_readdata <= mem_model[mem_address];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m0_read = 0; m0_write = 0; m0_address = '0; m0_byteenable = 4'hF; m0_writedata = '0;
    m1_read = 0; m1_write = 0; m1_address = '0; m1_byteenable = 4'hF; m1_writedata = '0;
  endtask

  initial begin
    int p;
    int owner;
    int exp_addr;
    n_checks = 0;
    n_fail   = 0;
    err_clr  = 0;
    reset_n  = 0;
    idle();
    m0_read = 1; m0_address = 14'h0010;

    // reset state
    $display("txn: reset with m0 requesting");
    @(negedge clk);
    check("rst_m0_wait", m0_waitrequest, 1);
    check("rst_m1_wait", m1_waitrequest, 0);
    check("rst_cs", mem_chipselect, 0);
    check("rst_clken", mem_clken, 0);
    check("rst_m0_valid", m0_readdatavalid, 0);
    check("rst_err", err_oor, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1; m0_read = 0;
    @(negedge clk);

    // simultaneous reads: m0 wins the first tie
    $display("txn: m0 read 0x0010 and m1 read 0x0020 same cycle");
    next_cycle();
    m0_read = 1; m0_address = 14'h0010; m1_read = 1; m1_address = 14'h0020;
    @(negedge clk);
    check("tie_m0_wait", m0_waitrequest, 0);
    check("tie_m1_wait", m1_waitrequest, 1);
    check("tie_addr", 32'(mem_address), 32'h10);
    check("tie_cs", mem_chipselect, 1);
    next_cycle();
    m0_read = 0;
    @(negedge clk);
    check("tie_m1_wait2", m1_waitrequest, 0);
    check("tie_addr2", 32'(mem_address), 32'h20);
    check("tie_m0_valid", m0_readdatavalid, 1);
    check("tie_m0_data", m0_readdata, 32'hC0DE0010);
    check("tie_m1_valid_early", m1_readdatavalid, 0);
    next_cycle();
    m1_read = 0;
    @(negedge clk);
    check("tie_m1_valid", m1_readdatavalid, 1);
    check("tie_m1_data", m1_readdata, 32'hC0DE0020);
    check("tie_m0_data_zero", m0_readdata, 0);
    check("tie_cs_idle", mem_chipselect, 0);
    check("tie_clken_pending", mem_clken, 1);
    next_cycle();
    @(negedge clk);
    check("idle_clken", mem_clken, 0);
    check("idle_m1_data", m1_readdata, 0);

    // partial write then read back
    $display("txn: m0 write 0xA5A5A5A5 be 0x3 to 0x0100");
    next_cycle();
    m0_write = 1; m0_address = 14'h0100; m0_byteenable = 4'h3; m0_writedata = 32'hA5A5A5A5;
    @(negedge clk);
    check("wr_mem_write", mem_write, 1);
    check("wr_m0_wait", m0_waitrequest, 0);
    check("wr_be", 32'(mem_byteenable), 32'h3);
    check("wr_data", mem_writedata, 32'hA5A5A5A5);
    $display("txn: m0 read 0x0100");
    next_cycle();
    m0_write = 0; m0_read = 1; m0_byteenable = 4'hF;
    @(negedge clk);
    check("wr_pulse_end", mem_write, 0);
    check("wr_no_valid", m0_readdatavalid, 0);
    next_cycle();
    m0_read = 0;
    @(negedge clk);
    check("rb_valid", m0_readdatavalid, 1);
    check("rb_data", m0_readdata, 32'hC0DEA5A5);

    // read+write together acts as a write
    $display("txn: m1 read+write 0x12345678 to 0x0104, then read");
    next_cycle();
    m1_read = 1; m1_write = 1; m1_address = 14'h0104; m1_writedata = 32'h12345678;
    @(negedge clk);
    check("rw_mem_write", mem_write, 1);
    next_cycle();
    m1_write = 0;
    @(negedge clk);
    check("rw_no_valid", m1_readdatavalid, 0);
    next_cycle();
    m1_read = 0;
    @(negedge clk);
    check("rw_rb_data", m1_readdata, 32'h12345678);

    // last valid word
    $display("txn: m1 read 11999");
    next_cycle();
    m1_read = 1; m1_address = 14'(11999);
    @(negedge clk);
    check("edge_cs", mem_chipselect, 1);
    next_cycle();
    m1_read = 0;
    @(negedge clk);
    check("edge_data", m1_readdata, 32'hC0DE2EDF);
    check("edge_err", err_oor, 0);

    // out of range read
    $display("txn: m1 read 12000 (out of range)");
    next_cycle();
    m1_read = 1; m1_address = 14'(12000);
    @(negedge clk);
    check("oor_cs", mem_chipselect, 0);
    check("oor_wait", m1_waitrequest, 0);
    check("oor_clken", mem_clken, 1);
    next_cycle();
    m1_read = 0;
    @(negedge clk);
    check("oor_valid", m1_readdatavalid, 1);
    check("oor_data", m1_readdata, 0);
    check("oor_err_set", err_oor, 1);
    $display("txn: err_clr pulse");
    next_cycle();
    err_clr = 1;
    next_cycle();
    err_clr = 0;
    @(negedge clk);
    check("oor_err_clr", err_oor, 0);
    $display("txn: err_clr coincident with m1 write 12001");
    next_cycle();
    err_clr = 1; m1_write = 1; m1_address = 14'(12001);
    @(negedge clk);
    check("oor_wr_mem_write", mem_write, 0);
    check("oor_wr_cs", mem_chipselect, 0);
    next_cycle();
    err_clr = 0; m1_write = 0;
    @(negedge clk);
    check("oor_set_wins", err_oor, 1);
    check("oor_wr_no_valid", m1_readdatavalid, 0);
    next_cycle();
    err_clr = 1;
    next_cycle();
    err_clr = 0;

    // continuous dual streams: strict alternation, one valid per cycle
    for (int c = 0; c <= 16; c++) begin
      next_cycle();
      m0_read = (c < 15); m0_address = ADDR_W'(32'h200 + (c + 1) / 2);
      m1_read = (c < 16); m1_address = ADDR_W'(32'h300 + c / 2);
      @(negedge clk);
      if (c < 16) begin
        $display("txn: stream cycle %0d grant m%0d", c, c % 2);
        check("str_m0_wait", m0_waitrequest, 32'((c % 2 == 1) && (c < 15)));
        check("str_m1_wait", m1_waitrequest, 32'(c % 2 == 0));
        check("str_addr", 32'(mem_address), (c % 2 == 0) ? 32'h200 + c / 2 : 32'h300 + c / 2);
      end
      if (c >= 1) begin
        p = c - 1;
        owner = p % 2;
        exp_addr = owner ? 32'h300 + p / 2 : 32'h200 + p / 2;
        check("str_valid", {m1_readdatavalid, m0_readdatavalid}, owner ? 2 : 1);
        check("str_data", owner ? m1_readdata : m0_readdata, 32'hC0DE0000 | 32'(exp_addr));
      end
    end
    idle();

    // reset during a granted read
    $display("txn: m0 read 0x0040 with reset pulse in grant cycle");
    next_cycle();
    m0_read = 1; m0_address = 14'h0040;
    @(negedge clk);
    check("rg_wait", m0_waitrequest, 0);
    #1 reset_n = 0;
    #1;
    check("rg_wait_in_rst", m0_waitrequest, 1);
    check("rg_cs_in_rst", mem_chipselect, 0);
    next_cycle();
    reset_n = 1; m0_read = 0;
    @(negedge clk);
    check("rg_no_valid", m0_readdatavalid, 0);
    check("rg_clken", mem_clken, 0);
    $display("txn: tie after reset");
    next_cycle();
    m0_read = 1; m1_read = 1; m0_address = 14'h0001; m1_address = 14'h0002;
    @(negedge clk);
    check("rg_tie_m0", m0_waitrequest, 0);
    check("rg_tie_m1", m1_waitrequest, 1);
    next_cycle();
    idle();
    next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
